ifft_frame_player: RTL
======================

Name: ifft_frame_player

Overview:
- Downstream stage of the FFT→IFFT chain.
- Captures each 512-point frame of IFFT real output, which arrives in bursts at clock rate and is tagged with the IFFT output index, into a ping-pong frame buffer.
- Plays the captured samples out to the codec one per codec sample-request strobe.
- Decouples the burst-rate IFFT output from the audio-rate codec and flags overrun, underrun and index errors.

Parameters:
- LOG_DEPTH, 9, log2 of frame length; frame = 512 samples.
- WIDTH, 18, sample width; matches codec and IFFT real output.
- OUT_SHIFT, 0, left-shift gain applied to played-out samples (0..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  IFFT real output sample, two's complement.
- in_valid  in  1  in_data/in_index valid this cycle.
- in_index  in  LOG_DEPTH  IFFT output index of in_data.
- sample_req  in  1  one-cycle codec request for the next sample.
- to_codec_data  out  WIDTH  sample presented to codec, registered.
- frame_loaded  out  1  one-cycle pulse when a complete frame is committed to a bank.
- playing  out  1  high while the reader is in R_PLAY.
- underrun  out  1  sticky: a frame ended with no full bank queued.
- overrun  out  1  sticky: a frame was dropped because no bank was free.
- index_err  out  1  sticky: out-of-order index aborted a frame.

Behaviour:
- Storage: two banks of 2^LOG_DEPTH x WIDTH, inferred RAM with registered read. Each bank has a state FREE, FILLING, FULL or PLAYING.
- Reset: all banks FREE; writer W_IDLE; reader R_WAIT; to_codec_data=0; all flags and pulses 0; addresses 0. Reset mid-frame discards all data.
- Writer FSM, state W_IDLE:
  - in_valid with in_index==0 and a FREE bank present: claim the lowest-numbered FREE bank, write sample 0, set it FILLING, go to W_FILL with expect=1.
  - in_valid with index 0 and no FREE bank: set overrun, go to W_DROP.
  - in_valid with index!=0: ignored.
- Writer FSM, state W_FILL:
  - in_valid with in_index==expect: write the sample, expect++.
  - Index 511 written: bank set FULL, frame_loaded pulses the next cycle, go to W_IDLE.
  - in_valid with in_index!=expect: bank returned to FREE, set index_err, go to W_IDLE. An index-0 sample arriving in that same cycle is not captured.
  - Gaps in in_valid are allowed.
- Writer FSM, state W_DROP: ignores samples until index 511 has been seen or a sample with index 0 arrives, then goes to W_IDLE. An index-0 sample that ends W_DROP is re-evaluated the next cycle and is not captured.
- Reader FSM, state R_WAIT:
  - to_codec_data holds its last value; 0 after reset.
  - sample_req ignored.
  - When any bank is FULL (lower-numbered bank first on a tie): mark it PLAYING, raddr=0, go to R_PLAY.
- Reader FSM, state R_PLAY:
  - sample_req: read bank[raddr]; to_codec_data updates exactly 1 cycle after sample_req; raddr++.
  - After the read of address 511: bank set FREE the same cycle.
  - If the other bank is FULL: switch to it immediately, raddr=0, no gap; the next sample_req reads that bank's sample 0.
  - Otherwise: set underrun, go to R_WAIT.
  - sample_req on consecutive cycles is supported, one sample per request.
- Simultaneous events:
  - The writer may claim a bank in the same cycle the reader frees it; the FREE transition is visible to the writer in that cycle.
  - Write and read never target the same bank.
- Output scaling: the sample is shifted left by OUT_SHIFT. Without the optional feature the result is truncated to WIDTH (wraps).
- The flags clear only on reset.
- Expected implementation size: 120-400 lines of RTL.

Optional Feature:
- Macro: OUTPUT_SATURATE_EN.
- Defined: after the OUT_SHIFT shift, any value outside the WIDTH signed range is clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1) (18'h1FFFF or 18'h20000).
- Undefined: plain truncation to WIDTH; overflowing values wrap.
- OUT_SHIFT=0: identical behaviour with or without the macro.

Test Plan:
- Ramp frame: after reset, feed index 0..511 with data=index, then 512 sample_req spaced 8 cycles → to_codec_data equals 0,1,...,511, each 1 cycle after its sample_req; frame_loaded pulses once; underrun=1 after the 512th read; playing drops.
- Back-to-back: load frame A (data=100) and frame B (data=200), play 1024 requests → 512 samples of 100, then 200 with no gap; underrun set only after request 1024.
- Overrun: load two frames without any sample_req, then feed a third frame → overrun=1; the third frame is ignored; playback yields only frames 1 and 2.
- Index error: feed index 0..99, then index 150 → index_err=1; bank freed; a subsequent clean frame 0..511 loads and plays correctly.
- Reset mid-play: assert reset for 1 cycle at request 300 → to_codec_data=0; all flags 0; playing=0; the next sample_req is ignored until a new frame loads.
- Saturation: OUT_SHIFT=2, in_data=18'h10000 → with OUTPUT_SATURATE_EN defined, output 18'h1FFFF; without it, output 18'h00000.

Source files
------------

// File: rtl/ifft_frame_player_if.sv
// Port bundle for ifft_frame_player: IFFT burst input, codec request strobe and status outputs.
interface ifft_frame_player_if #(
  parameter int LOG_DEPTH = 9,
  parameter int WIDTH     = 18
);
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic [LOG_DEPTH-1:0] in_index;
  logic                 sample_req;
  logic [WIDTH-1:0]     to_codec_data;
  logic                 frame_loaded;
  logic                 playing;
  logic                 underrun;
  logic                 overrun;
  logic                 index_err;

  modport master (
    output in_data, in_valid, in_index, sample_req,
    input  to_codec_data, frame_loaded, playing, underrun, overrun, index_err
  );

  modport slave (
    input  in_data, in_valid, in_index, sample_req,
    output to_codec_data, frame_loaded, playing, underrun, overrun, index_err
  );
endinterface

// File: rtl/ifft_frame_player.sv
// Ping-pong frame buffer between the IFFT burst output and the audio-rate codec.
// Define OUTPUT_SATURATE_EN to clamp the shifted output instead of letting it wrap.
module ifft_frame_player #(
  parameter int LOG_DEPTH = 9,
  parameter int WIDTH     = 18,
  parameter int OUT_SHIFT = 0
) (
  input logic clk,
  input logic reset,
  ifft_frame_player_if.slave io
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_PLAYING} bank_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
  typedef enum logic {R_WAIT, R_PLAY} rd_state_t;

  bank_state_t          bank_state_reg [2];
  wr_state_t            w_state_reg;
  rd_state_t            r_state_reg;
  logic                 wbank_reg;
  logic [LOG_DEPTH-1:0] expect_reg;
  logic                 rbank_reg;
  logic [LOG_DEPTH-1:0] raddr_reg;
  logic                 out_sel_reg;
  logic                 frame_loaded_reg;
  logic                 underrun_reg;
  logic                 overrun_reg;
  logic                 index_err_reg;

  logic       rd_en;
  logic       rd_last;
  logic [1:0] free_vec;
  logic       claim_bank;
  logic       wr_en;
  logic       wr_bank;

  assign rd_en   = (r_state_reg == R_PLAY) && io.sample_req;
  assign rd_last = rd_en && (raddr_reg == LAST_ADDR);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_free
      // A bank being released by the reader this cycle is already claimable.
      assign free_vec[gi] = (bank_state_reg[gi] == B_FREE) || (rd_last && (rbank_reg == 1'(gi)));
    end
  endgenerate

  assign claim_bank = ~free_vec[0];
  assign wr_en = io.in_valid &&
                 (((w_state_reg == W_IDLE) && (io.in_index == '0) && (|free_vec)) ||
                  ((w_state_reg == W_FILL) && (io.in_index == expect_reg)));
  assign wr_bank = (w_state_reg == W_IDLE) ? claim_bank : wbank_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [WIDTH-1:0] mem [DEPTH];
      logic [WIDTH-1:0] rd_q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_bank == 1'(gi)))
          mem[io.in_index] <= io.in_data;
      end

      always_ff @(posedge clk) begin
        if (reset)
          rd_q_reg <= '0;
        else if (rd_en && (rbank_reg == 1'(gi)))
          rd_q_reg <= mem[raddr_reg];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_state_reg[0] <= B_FREE;
      bank_state_reg[1] <= B_FREE;
      w_state_reg       <= W_IDLE;
      r_state_reg       <= R_WAIT;
      wbank_reg         <= 1'b0;
      expect_reg        <= '0;
      rbank_reg         <= 1'b0;
      raddr_reg         <= '0;
      out_sel_reg       <= 1'b0;
      frame_loaded_reg  <= 1'b0;
      underrun_reg      <= 1'b0;
      overrun_reg       <= 1'b0;
      index_err_reg     <= 1'b0;
    end else begin
      frame_loaded_reg <= 1'b0;

      case (r_state_reg)
        R_WAIT: begin
          if (bank_state_reg[0] == B_FULL) begin
            bank_state_reg[0] <= B_PLAYING;
            rbank_reg         <= 1'b0;
            raddr_reg         <= '0;
            r_state_reg       <= R_PLAY;
          end else if (bank_state_reg[1] == B_FULL) begin
            bank_state_reg[1] <= B_PLAYING;
            rbank_reg         <= 1'b1;
            raddr_reg         <= '0;
            r_state_reg       <= R_PLAY;
          end
        end
        R_PLAY: begin
          if (rd_en) begin
            raddr_reg   <= raddr_reg + 1'b1;
            out_sel_reg <= rbank_reg;
            if (raddr_reg == LAST_ADDR) begin
              bank_state_reg[rbank_reg] <= B_FREE;
              // Seamless hand-over when the other bank is already queued.
              if (bank_state_reg[~rbank_reg] == B_FULL) begin
                bank_state_reg[~rbank_reg] <= B_PLAYING;
                rbank_reg                  <= ~rbank_reg;
                raddr_reg                  <= '0;
              end else begin
                underrun_reg <= 1'b1;
                r_state_reg  <= R_WAIT;
              end
            end
          end
        end
        default: r_state_reg <= R_WAIT;
      endcase

      // Writer updates come last so a claim of a just-released bank wins over the release.
      case (w_state_reg)
        W_IDLE: begin
          if (io.in_valid && (io.in_index == '0)) begin
            if (|free_vec) begin
              bank_state_reg[claim_bank] <= B_FILLING;
              wbank_reg                  <= claim_bank;
              expect_reg                 <= LOG_DEPTH'(1);
              w_state_reg                <= W_FILL;
            end else begin
              overrun_reg <= 1'b1;
              w_state_reg <= W_DROP;
            end
          end
        end
        W_FILL: begin
          if (io.in_valid) begin
            if (io.in_index == expect_reg) begin
              expect_reg <= expect_reg + 1'b1;
              if (expect_reg == LAST_ADDR) begin
                bank_state_reg[wbank_reg] <= B_FULL;
                frame_loaded_reg          <= 1'b1;
                w_state_reg               <= W_IDLE;
              end
            end else begin
              bank_state_reg[wbank_reg] <= B_FREE;
              index_err_reg             <= 1'b1;
              w_state_reg               <= W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (io.in_valid && ((io.in_index == LAST_ADDR) || (io.in_index == '0)))
            w_state_reg <= W_IDLE;
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Output gain stage on the registered RAM word; five guard bits cover shifts up to 4.
  logic [WIDTH-1:0]        raw_word;
  logic signed [WIDTH+4:0] wide_word;
  logic [WIDTH-1:0]        out_word;

  assign raw_word  = out_sel_reg ? g_bank[1].rd_q_reg : g_bank[0].rd_q_reg;
  assign wide_word = $signed({{5{raw_word[WIDTH-1]}}, raw_word}) <<< OUT_SHIFT;

`ifdef OUTPUT_SATURATE_EN
  localparam logic signed [WIDTH+4:0] SAT_MAX = {6'b000000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+4:0] SAT_MIN = {6'b111111, {(WIDTH-1){1'b0}}};

  always_comb begin
    out_word = wide_word[WIDTH-1:0];
    if (wide_word > SAT_MAX)
      out_word = {1'b0, {(WIDTH-1){1'b1}}};
    else if (wide_word < SAT_MIN)
      out_word = {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign out_word = wide_word[WIDTH-1:0];
`endif

  assign io.to_codec_data = out_word;
  assign io.frame_loaded  = frame_loaded_reg;
  assign io.playing       = (r_state_reg == R_PLAY);
  assign io.underrun      = underrun_reg;
  assign io.overrun       = overrun_reg;
  assign io.index_err     = index_err_reg;
endmodule
